// File: rtl/block_accumulator.sv
// Accumulates a stream of 2x2 single-precision partial products into one output tile,
// using four lockstep floating-point adders with a stb/ack result handshake.

module fp_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        input_z_ack
);
    localparam logic [1:0] A_GET  = 2'd0;
    localparam logic [1:0] A_CALC = 2'd1;
    localparam logic [1:0] A_PUT  = 2'd2;

    logic [1:0]  state_r;
    logic [31:0] a_r;
    logic [31:0] b_r;

    // Round-to-nearest-even add with guard/round/sticky bits; denormals handled via exponent 1.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf;
        logic [31:0] x, y;
        logic [7:0]  eex, eey, d;
        logic [26:0] ax, ay, tmp, ay_sh;
        logic        lost, rnd;
        logic [27:0] s;
        logic [9:0]  e;
        logic [23:0] m;
        logic [24:0] mr;
        logic [7:0]  ef;
        a_nan = (&a[30:23]) & (|a[22:0]);
        b_nan = (&b[30:23]) & (|b[22:0]);
        a_inf = (&a[30:23]) & ~(|a[22:0]);
        b_inf = (&b[30:23]) & ~(|b[22:0]);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            return 32'h7fc00000;
        end
        if (a_inf) begin
            return a;
        end
        if (b_inf) begin
            return b;
        end
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        eex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        eey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        ax  = {(x[30:23] != 8'd0), x[22:0], 3'b000};
        ay  = {(y[30:23] != 8'd0), y[22:0], 3'b000};
        d   = eex - eey;
        if (d >= 8'd27) begin
            ay_sh = {26'd0, |ay};
        end else begin
            tmp   = ay >> d;
            lost  = |(ay & ((27'd1 << d) - 27'd1));
            ay_sh = {tmp[26:1], tmp[0] | lost};
        end
        if (x[31] == y[31]) begin
            s = {1'b0, ax} + {1'b0, ay_sh};
        end else begin
            s = {1'b0, ax} - {1'b0, ay_sh};
        end
        if (s == 28'd0) begin
            return {x[31] & y[31], 31'd0};
        end
        e = {2'b00, eex};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && (e > 10'd1)) begin
                    s = {s[26:0], 1'b0};
                    e = e - 10'd1;
                end
            end
        end
        m   = s[26:3];
        rnd = s[2] & (s[1] | s[0] | m[0]);
        mr  = {1'b0, m} + {24'd0, rnd};
        if (mr[24]) begin
            mr = {1'b0, mr[24:1]};
            e  = e + 10'd1;
        end
        if (e >= 10'd255) begin
            return {x[31], 8'hff, 23'd0};
        end
        ef = mr[23] ? e[7:0] : 8'd0;
        return {x[31], ef, mr[22:0]};
    endfunction

    // Handshake sequencer: take both operands, compute, hold the result until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= A_GET;
            a_r          <= 32'd0;
            b_r          <= 32'd0;
            output_z     <= 32'd0;
            output_z_stb <= 1'b0;
        end else if (rst) begin
            state_r      <= A_GET;
            a_r          <= 32'd0;
            b_r          <= 32'd0;
            output_z     <= 32'd0;
            output_z_stb <= 1'b0;
        end else begin
            case (state_r)
                A_GET: begin
                    if (input_a_stb && input_b_stb) begin
                        a_r     <= input_a;
                        b_r     <= input_b;
                        state_r <= A_CALC;
                    end
                end
                A_CALC: begin
                    output_z     <= fp_add(a_r, b_r);
                    output_z_stb <= 1'b1;
                    state_r      <= A_PUT;
                end
                A_PUT: begin
                    if (input_z_ack) begin
                        output_z_stb <= 1'b0;
                        state_r      <= A_GET;
                    end
                end
                default: state_r <= A_GET;
            endcase
        end
    end
endmodule

module block_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_num_blocks,
    input  logic [31:0]      i_p11,
    input  logic [31:0]      i_p12,
    input  logic [31:0]      i_p21,
    input  logic [31:0]      i_p22,
    input  logic             i_p_valid,
    output logic [31:0]      o_c11,
    output logic [31:0]      o_c12,
    output logic [31:0]      o_c21,
    output logic [31:0]      o_c22,
    output logic             o_valid,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overrun
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        state_r;
    logic [3:0][31:0]  acc_r;
    logic [3:0][31:0]  part_r;
    logic [3:0][31:0]  sum_s;
    logic [3:0]        z_stb_s;
    logic [3:0][31:0]  p_in_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  target_r;
    logic [CNT_W-1:0]  target_s;
    logic [CNT_W-1:0]  count_inc_s;
    logic              adder_rst_r;
    logic              add_stb_r;

    assign p_in_s      = {i_p22, i_p21, i_p12, i_p11};
    assign target_s    = (i_num_blocks == {CNT_W{1'b0}}) ? CNT_ONE : i_num_blocks;
    assign count_inc_s = (count_r == CNT_MAX) ? count_r : count_r + CNT_ONE;
    assign o_count     = count_r;

    // One adder per lane; operand a is the running sum, b the registered partial product.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        fp_adder u_add (
            .clk          (clk),
            .rst_n        (rst_n),
            .rst          (adder_rst_r),
            .input_a      (acc_r[g]),
            .input_a_stb  (add_stb_r),
            .input_b      (part_r[g]),
            .input_b_stb  (add_stb_r),
            .output_z     (sum_s[g]),
            .output_z_stb (z_stb_s[g]),
            .input_z_ack  (add_stb_r)
        );
    end

    // Tile sequencer: first partial loads directly, later ones go through the adders.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            acc_r       <= '0;
            part_r      <= '0;
            count_r     <= {CNT_W{1'b0}};
            target_r    <= CNT_ONE;
            adder_rst_r <= 1'b1;
            add_stb_r   <= 1'b0;
            o_c11       <= 32'd0;
            o_c12       <= 32'd0;
            o_c21       <= 32'd0;
            o_c22       <= 32'd0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else if (i_clear) begin
            state_r     <= S_IDLE;
            count_r     <= {CNT_W{1'b0}};
            adder_rst_r <= 1'b1;
            add_stb_r   <= 1'b0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            add_stb_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_p_valid) begin
                        acc_r    <= p_in_s;
                        count_r  <= CNT_ONE;
                        target_r <= target_s;
                        state_r  <= (target_s == CNT_ONE) ? S_OUT : S_ACC;
                    end else begin
                        count_r <= {CNT_W{1'b0}};
                    end
                end
                S_ACC: begin
                    if (i_p_valid) begin
                        part_r      <= p_in_s;
                        adder_rst_r <= 1'b0;
                        add_stb_r   <= 1'b1;
                        o_busy      <= 1'b1;
                        state_r     <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (i_p_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (&z_stb_s) begin
                        acc_r       <= sum_s;
                        count_r     <= count_inc_s;
                        adder_rst_r <= 1'b1;
                        o_busy      <= 1'b0;
                        state_r     <= (count_inc_s == target_r) ? S_OUT : S_ACC;
                    end
                end
                S_OUT: begin
                    if (i_p_valid) begin
                        o_overrun <= 1'b1;
                    end
                    o_valid <= 1'b1;
                    o_c11   <= acc_r[0];
                    o_c12   <= acc_r[1];
                    o_c21   <= acc_r[2];
                    o_c22   <= acc_r[3];
                    state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_accumulator.sv
// Directed bench for block_accumulator: table of tiles plus hand-written reset/clear/overrun sequences.

module tb_block_accumulator;
    localparam int ADD_LAT = 3;   // i_p_valid edge to all four z_stb high

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_clear = 1'b0;
    logic [7:0]  i_num_blocks = 8'd1;
    logic [31:0] i_p11 = 32'd0, i_p12 = 32'd0, i_p21 = 32'd0, i_p22 = 32'd0;
    logic        i_p_valid = 1'b0;
    logic [31:0] o_c11, o_c12, o_c21, o_c22;
    logic        o_valid, o_busy, o_overrun;
    logic [7:0]  o_count;
    logic [3:0][31:0] oc;

    int checks = 0;
    int errors = 0;

    assign oc = {o_c22, o_c21, o_c12, o_c11};

    always #5 clk = ~clk;

    block_accumulator #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_num_blocks(i_num_blocks),
        .i_p11(i_p11), .i_p12(i_p12), .i_p21(i_p21), .i_p22(i_p22), .i_p_valid(i_p_valid),
        .o_c11(o_c11), .o_c12(o_c12), .o_c21(o_c21), .o_c22(o_c22),
        .o_valid(o_valid), .o_busy(o_busy), .o_count(o_count), .o_overrun(o_overrun)
    );

    typedef struct {
        logic [7:0]       nb;
        int               np;
        logic [3:0][31:0] p0;
        logic [3:0][31:0] p1;
        logic [3:0][31:0] p2;
        logic [3:0][31:0] exp_c;
        logic [7:0]       exp_cnt;
        int               exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [3:0][31:0] p);
        @(negedge clk);
        {i_p22, i_p21, i_p12, i_p11} = p;
        i_p_valid = 1'b1;
        @(negedge clk);
        i_p_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int pulses,
                               output logic [3:0][31:0] res, output logic [7:0] cnt);
        lat = 0; pulses = 0; res = '0; cnt = 8'd0;
        for (int k = 1; k <= 20; k++) begin
            if (o_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat = k; res = oc; cnt = o_count;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
    endtask

    int lat, pulses;
    logic [3:0][31:0] res, last_res;
    logic [7:0] cnt;

    initial begin
        vecs[0] = '{8'd1, 1, {4{32'h3f800000}}, '0, '0, {4{32'h3f800000}}, 8'd1, 2};
        vecs[1] = '{8'd2, 2, {4{32'h3f800000}}, {4{32'h40000000}}, '0, {4{32'h40400000}}, 8'd2, ADD_LAT + 2};
        vecs[2] = '{8'd3, 3, {4{32'h3f000000}}, {4{32'h3f000000}}, {4{32'h3f800000}},
                    {4{32'h40000000}}, 8'd3, ADD_LAT + 2};
        vecs[3] = '{8'd0, 1, {4{32'h4158a3d7}}, '0, '0, {4{32'h4158a3d7}}, 8'd1, 2};
        // lanes c11..c22: 1+1, 1+(-1), 1.5+0.25, 2+(-0.5)
        vecs[4] = '{8'd2, 2, {32'h40000000, 32'h3fc00000, 32'h3f800000, 32'h3f800000},
                    {32'hbf000000, 32'h3e800000, 32'hbf800000, 32'h3f800000}, '0,
                    {32'h3fc00000, 32'h3fe00000, 32'h00000000, 32'h40000000}, 8'd2, ADD_LAT + 2};

        repeat (2) @(negedge clk);
        chk("rst_c11", o_c11, 32'd0);
        chk("rst_c22", o_c22, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
        chk("rst_count", {24'd0, o_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            i_num_blocks = vecs[v].nb;
            send(vecs[v].p0);
            if (vecs[v].np >= 2) send(vecs[v].p1);
            if (vecs[v].np >= 3) begin
                repeat (4) @(negedge clk);
                send(vecs[v].p2);
            end
            wait_result(lat, pulses, res, cnt);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_pulses", v), pulses, 1);
            for (int l = 0; l < 4; l++) chk($sformatf("v%0d_lane%0d", v, l), res[l], vecs[v].exp_c[l]);
            chk($sformatf("v%0d_count", v), {24'd0, cnt}, {24'd0, vecs[v].exp_cnt});
        end
        last_res = vecs[4].exp_c;
        repeat (5) @(negedge clk);
        for (int l = 0; l < 4; l++) chk($sformatf("hold_lane%0d", l), oc[l], last_res[l]);

        // Overrun: third partial arrives while the adders are busy
        i_num_blocks = 8'd2;
        send({4{32'h3f800000}});
        send({4{32'h40000000}});
        chk("ovr_busy", {31'd0, o_busy}, 32'd1);
        send({4{32'h40a00000}});
        wait_result(lat, pulses, res, cnt);
        chk("ovr_pulses", pulses, 1);
        chk("ovr_c11", res[0], 32'h40400000);
        chk("ovr_c22", res[3], 32'h40400000);
        chk("ovr_flag", {31'd0, o_overrun}, 32'd1);
        pulse_clear();
        chk("ovr_cleared", {31'd0, o_overrun}, 32'd0);

        // Reset while the adders are in flight
        send({4{32'h3f800000}});
        send({4{32'h40000000}});
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_c11", o_c11, 32'd0);
        chk("midrst_count", {24'd0, o_count}, 32'd0);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        rst_n = 1'b1;
        wait_result(lat, pulses, res, cnt);
        chk("midrst_pulses", pulses, 0);
        i_num_blocks = 8'd1;
        send({4{32'h3f800000}});
        wait_result(lat, pulses, res, cnt);
        chk("postrst_pulses", pulses, 1);
        chk("postrst_c21", res[2], 32'h3f800000);

        // Clear in the middle of a three-partial tile
        i_num_blocks = 8'd3;
        send({4{32'h3f000000}});
        send({4{32'h3f000000}});
        repeat (4) @(negedge clk);
        chk("midclr_count_before", {24'd0, o_count}, 32'd2);
        pulse_clear();
        chk("midclr_count", {24'd0, o_count}, 32'd0);
        wait_result(lat, pulses, res, cnt);
        chk("midclr_pulses", pulses, 0);
        chk("midclr_hold_c12", o_c12, 32'h3f800000);

        // Clear wins over a simultaneous partial product
        i_num_blocks = 8'd1;
        @(negedge clk);
        {i_p22, i_p21, i_p12, i_p11} = {4{32'h40000000}};
        i_clear = 1'b1; i_p_valid = 1'b1;
        @(negedge clk);
        i_clear = 1'b0; i_p_valid = 1'b0;
        chk("clrprio_count", {24'd0, o_count}, 32'd0);
        wait_result(lat, pulses, res, cnt);
        chk("clrprio_pulses", pulses, 0);
        send({4{32'h3f800000}});
        wait_result(lat, pulses, res, cnt);
        chk("postclr_c11", res[0], 32'h3f800000);

        // Maximum target: 255 zero partials
        i_num_blocks = 8'd255;
        send('0);
        send('0);
        for (int n = 2; n < 255; n++) begin
            repeat (4) @(negedge clk);
            send('0);
        end
        wait_result(lat, pulses, res, cnt);
        chk("sat_pulses", pulses, 1);
        chk("sat_count", {24'd0, cnt}, 32'd255);
        chk("sat_c22", res[3], 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/block_accumulator.md
BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

Interface
REQ-001 Parameter CNT_W, default 8: width of the partial-product count and of i_num_blocks.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 i_clear  input  1  synchronous abort of the current tile; restarts accumulation.
REQ-005 i_num_blocks  input  CNT_W  number of 2x2 partial products per output tile; 0 is treated as 1.
REQ-006 i_p11, i_p12, i_p21, i_p22  input  32 each  IEEE-754 single-precision 2x2 partial product.
REQ-007 i_p_valid  input  1  one-cycle pulse qualifying i_p11..i_p22; driven by the base multiplier done output.
REQ-008 o_c11, o_c12, o_c21, o_c22  output  32 each  accumulated tile result.
REQ-009 o_valid  output  1  one-cycle pulse; o_c* hold the final sum for the tile.
REQ-010 o_busy  output  1  high while the lane additions are in flight (state S_ADD).
REQ-011 o_count  output  CNT_W  number of partial products absorbed into the current tile.
REQ-012 o_overrun  output  1  sticky flag: a partial product arrived while busy and was dropped.

Function
REQ-013 Four lanes (c11, c12, c21, c22), each with one instance of the codebase single-precision adder using the stb/ack handshake; all four lanes operate in lockstep.
REQ-014 States: S_IDLE (count 0), S_ACC (waiting for the next partial product), S_ADD (adds in flight), S_OUT (result pulse).
REQ-015 S_IDLE + i_p_valid: load i_p* directly into the accumulators with no addition, set count to 1, and latch i_num_blocks (0 becomes 1) as the target.
REQ-016 After that load, go to S_OUT if count equals the target; otherwise go to S_ACC.
REQ-017 S_ACC + i_p_valid: register i_p*, release the adders from reset, assert a_stb, b_stb and z_ack for one cycle (operand a = accumulator, b = partial), then go to S_ADD.
REQ-018 S_ADD: wait until all four adder output_z_stb signals are high at once, then capture the four sums into the accumulators and increment count.
REQ-019 On that capture, return the adders to reset and go to S_OUT if count equals the target, else to S_ACC.
REQ-020 S_OUT: o_valid is high for exactly one cycle, o_c* equal the accumulators, and the next state is S_IDLE.
REQ-021 Accumulation order is arrival order; rounding, NaN, Inf and signed-zero handling are those of the adder, with no extra logic.
REQ-022 Between tiles, o_c* keep their last value.
REQ-023 Latency for target 1: o_valid is high in the 2nd cycle after the i_p_valid edge.
REQ-024 Latency for each later partial product: adder latency + 2 cycles.
REQ-025 i_p_valid in S_ADD or S_OUT: set o_overrun, drop the sample, and leave the accumulators and count unchanged.
REQ-026 i_clear has priority over i_p_valid in the same cycle.
REQ-027 i_clear in any state: go to S_IDLE, set count to 0, clear o_overrun, hold the adders in reset, and produce no o_valid; o_c* are not cleared.
REQ-028 count saturates at 2^CNT_W-1; a target of 2^CNT_W-1 is therefore still reachable.

Reset
REQ-029 While rst_n is low: state S_IDLE; o_c* = 0; accumulators = 0; count = 0; o_valid, o_busy and o_overrun = 0; adder stb/ack = 0; adders held in reset.
REQ-030 rst_n asserted mid-S_ADD: the in-flight result is discarded, and the first i_p_valid after release starts a fresh tile.

Verification
REQ-031 Target 1; i_p* = 3f800000 (1.0) -> o_valid 2 cycles later; all o_c* = 3f800000; o_count = 1.
REQ-032 Target 2; p1 = 3f800000, then p2 = 40000000 (2.0) -> all o_c* = 40400000 (3.0); exactly one o_valid pulse.
REQ-033 Target 3; partials 3f000000, 3f000000, 3f800000 per lane -> o_c* = 40000000 (2.0).
REQ-034 Target 0; i_p* = 4158a3d7 -> treated as 1; o_c* = 4158a3d7.
REQ-035 Second i_p_valid while o_busy -> o_overrun = 1; the final result is unaffected; i_clear then clears o_overrun.
REQ-036 rst_n low mid-S_ADD, then i_clear mid-tile in a separate run -> no o_valid, count 0; a following target-1 tile with 3f800000 yields 3f800000.
